// File: rtl/proj_multi_hasher.sv
// Multi-seed pipelined MurmurHash3-style mixer: one kmer in, NUM_SEEDS signatures out.
// Optional fmix finalizer stage enabled by defining PROJ_HASHER_FMIX_EN.

module proj_multi_hasher_lane #(
  parameter int W        = 32,
  parameter int SEED_ROT = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] kr,
  output logic [W-1:0] sig
);
  localparam logic [W-1:0] N_C  = W'(32'he6546b64);
  localparam logic [W-1:0] MUL5 = W'(5);

  logic [2*W-1:0] seed_dbl;
  logic [W-1:0]   sr, x, s3;

  assign seed_dbl = {seed, seed} << SEED_ROT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      x  <= '0;
      s3 <= '0;
    end else if (en) begin
      sr <= seed_dbl[2*W-1:W];
      x  <= (sr ^ kr) * MUL5;
      s3 <= x + N_C;
    end
  end

`ifdef PROJ_HASHER_FMIX_EN
  localparam logic [W-1:0] FM1 = W'(32'h85ebca6b);
  localparam logic [W-1:0] FM2 = W'(32'hc2b2ae35);

  function automatic logic [W-1:0] fmix(input logic [W-1:0] h0);
    logic [W-1:0] h;
    h = h0;
    h = h ^ (h >> 16);
    h = h * FM1;
    h = h ^ (h >> 13);
    h = h * FM2;
    h = h ^ (h >> 16);
    return h;
  endfunction

  logic [W-1:0] s4;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  s4 <= '0;
    else if (en) s4 <= fmix(s3);
  end
  assign sig = s4;
`else
  assign sig = s3;
`endif
endmodule

module proj_multi_hasher #(
  parameter int HASHER_DATA_BITS = 32,
  parameter int NUM_SEEDS        = 4,
  parameter int KMER_ROT         = 15,
  parameter int SEED_ROT         = 13,
  parameter int CNT_BITS         = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [HASHER_DATA_BITS-1:0]           kmer,
  input  logic [NUM_SEEDS*HASHER_DATA_BITS-1:0] seeds,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_SEEDS*HASHER_DATA_BITS-1:0] signatures,
  output logic [CNT_BITS-1:0]                   kmer_count
);
  localparam int W = HASHER_DATA_BITS;
`ifdef PROJ_HASHER_FMIX_EN
  localparam int STAGES = 4;
`else
  localparam int STAGES = 3;
`endif
  localparam logic [W-1:0] C2 = W'(32'h1b873593);

  logic           en, acc;
  logic [2*W-1:0] kmer_dbl;
  logic [W-1:0]   kr;
  logic [STAGES:1] vld_pipe;

  // Single global enable: any stall freezes every stage, bubbles included.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign acc       = in_valid && en;
  assign out_valid = vld_pipe[STAGES];
  assign kmer_dbl  = {kmer, kmer} << KMER_ROT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      kr         <= '0;
      kmer_count <= '0;
    end else begin
      if (en) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], acc};
        kr       <= kmer_dbl[2*W-1:W] * C2;
      end
      if (acc) kmer_count <= kmer_count + CNT_BITS'(1);
    end
  end

  for (genvar i = 0; i < NUM_SEEDS; i++) begin : g_lane
    proj_multi_hasher_lane #(.W(W), .SEED_ROT(SEED_ROT)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .seed (seeds[i*W +: W]),
      .kr   (kr),
      .sig  (signatures[i*W +: W])
    );
  end
endmodule

// File: tb/tb_proj_multi_hasher.sv
// Self-checking bench for proj_multi_hasher: directed vectors, stall, reset, random traffic.
module tb_proj_multi_hasher;
  localparam int W  = 32;
  localparam int NS = 2;
  localparam int CB = 4;
`ifdef PROJ_HASHER_FMIX_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 0, rst_n = 0;
  logic          in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [W-1:0]  kmer = '0;
  logic [NS*W-1:0] seeds = '0, signatures;
  logic [CB-1:0] kmer_count;

  proj_multi_hasher #(.HASHER_DATA_BITS(W), .NUM_SEEDS(NS), .KMER_ROT(15),
                      .SEED_ROT(13), .CNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .kmer(kmer), .seeds(seeds), .out_valid(out_valid), .out_ready(out_ready),
    .signatures(signatures), .kmer_count(kmer_count));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [NS*W-1:0] exp_q[$];
  logic [CB-1:0]   cnt_m = '0;
  bit              prev_stall = 0;
  logic [NS*W-1:0] prev_sig;

  function automatic longint unsigned rol(input longint unsigned x, input int r);
    return ((x * (64'd1 << r)) % 64'h1_0000_0000) + x / (64'd1 << (32 - r));
  endfunction

  function automatic longint unsigned fmix_m(input longint unsigned h0);
    longint unsigned h;
    h = h0;
    h = h ^ (h / 65536);
    h = (h * 64'h85ebca6b) % 64'h1_0000_0000;
    h = h ^ (h / 8192);
    h = (h * 64'hc2b2ae35) % 64'h1_0000_0000;
    h = h ^ (h / 65536);
    return h;
  endfunction

  function automatic logic [NS*W-1:0] model(input logic [W-1:0] k, input logic [NS*W-1:0] s);
    logic [NS*W-1:0] r;
    longint unsigned kr, v;
    kr = (rol(64'(k), 15) * 64'h1b873593) % 64'h1_0000_0000;
    for (int i = 0; i < NS; i++) begin
      v = ((rol(64'(s[i*W +: W]), 13) ^ kr) * 5 + 64'he6546b64) % 64'h1_0000_0000;
`ifdef PROJ_HASHER_FMIX_EN
      v = fmix_m(v);
`endif
      r[i*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive inputs, score handshakes seen before the edge, then clock.
  task automatic tick(input bit iv, input logic [W-1:0] k, input logic [NS*W-1:0] s, input bit ordy);
    in_valid = iv; kmer = k; seeds = s; out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("stall_hold_valid", 128'(out_valid), 128'(1));
      check("stall_hold_sig", 128'(signatures), 128'(prev_sig));
    end
    if (out_valid && !out_ready) check("stall_in_ready", 128'(in_ready), 128'(0));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 128'(out_valid), 128'(0));
      else check("sig", 128'(signatures), 128'(exp_q.pop_front()));
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(k, s));
      cnt_m = cnt_m + 1'b1;
    end
    prev_stall = out_valid && !out_ready;
    prev_sig   = signatures;
    @(posedge clk); #1;
    check("kmer_count", 128'(kmer_count), 128'(cnt_m));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 40) begin
      tick(0, '0, '0, 1); n++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  function automatic logic [NS*W-1:0] rnd_seeds();
    logic [NS*W-1:0] s;
    for (int i = 0; i < NS; i++) s[i*W +: W] = $urandom;
    return s;
  endfunction

  initial begin
    int n;
    logic [NS*W-1:0] sv;
    // Reset state
    #3;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_count", 128'(kmer_count), 128'(0));
    check("rst_sig", 128'(signatures), 128'(0));
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;

    // Directed vector: kmer=0, seeds {lane1=1, lane0=0}; measure latency
    sv = {32'h1, 32'h0};
    tick(1, '0, sv, 1);
    n = 1;
    while (!out_valid && n < 20) begin tick(0, '0, '0, 1); n++; end
    check("latency", 128'(n), 128'(LAT));
`ifndef PROJ_HASHER_FMIX_EN
    check("vec_lane0", 128'(signatures[W-1:0]), 128'(32'he6546b64));
    check("vec_lane1", 128'(signatures[2*W-1:W]), 128'(32'he6550b64));
`else
    check("vec_fmix", 128'(signatures[W-1:0]), 128'(fmix_m(64'he6546b64)));
`endif
    check("count_one", 128'(kmer_count), 128'(1));
    drain();

    // kmer=1, seed=0 through the scoreboard
    tick(1, 32'h1, '0, 1);
    drain();

    // 8-kmer stream with out_ready low on cycles 5..9
    for (int c = 0; c < 14; c++)
      tick(c < 8, $urandom, rnd_seeds(), !(c >= 5 && c <= 9));
    drain();

    // Random traffic with random backpressure (also wraps the 4-bit counter)
    for (int c = 0; c < 300; c++)
      tick($urandom_range(0, 3) != 0, $urandom, rnd_seeds(), $urandom_range(0, 2) != 0);
    drain();

    // Reset with two kmers in flight
    tick(1, $urandom, rnd_seeds(), 1);
    tick(1, $urandom, rnd_seeds(), 1);
    #2 rst_n = 0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_count", 128'(kmer_count), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    exp_q.delete();
    cnt_m = '0;
    prev_stall = 0;
    @(posedge clk); #1; rst_n = 1;
    for (int c = 0; c < 8; c++) begin
      tick(0, '0, '0, 1);
      check("no_stale_out", 128'(out_valid), 128'(0));
    end

    // Traffic resumes cleanly after reset
    for (int c = 0; c < 20; c++)
      tick($urandom_range(0, 1) == 1, $urandom, rnd_seeds(), $urandom_range(0, 3) != 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
